// File: rtl/weight_pkg.sv
// weight_pkg: shared defaults and the saturating increment for the cabin load monitor.
package weight_pkg;
    localparam int WEIGHT_MAX_UNITS_D = 8;
    localparam int WEIGHT_CNT_W_D = 4;
    function automatic int unsigned sat_inc(input int unsigned count, input int unsigned max_v);
        return (count >= max_v) ? count : count + 1;
    endfunction
endpackage

// File: rtl/weight_edge_det.sv
// weight_edge_det: samples weight_flip (2-flop synchronized when WEIGHT_SYNC_EN is defined)
// and emits a one-cycle pulse on each 0->1 transition.
module weight_edge_det (
    input  logic clk,
    input  logic weight_flip_reset,
    input  logic weight_flip,
    output logic rise_o
);
    logic sync_q;
    logic prev_q;
`ifdef WEIGHT_SYNC_EN
    logic meta_q;
    always_ff @(posedge clk) begin
        meta_q <= weight_flip;
        sync_q <= meta_q;
    end
`else
    always_ff @(posedge clk) sync_q <= weight_flip;
`endif
    // prev tracks the sampled level through reset, so a level held across release is not a rise
    always_ff @(posedge clk) prev_q <= sync_q;
    assign rise_o = sync_q & ~prev_q & ~weight_flip_reset;
endmodule

// File: rtl/weight_limit.sv
// weight_limit: counts load-unit rises and raises a sticky over-limit flag once count > MAX_UNITS.
// Define WEIGHT_SYNC_EN to add a 2-flop synchronizer for an asynchronous sensor.
module weight_limit
    import weight_pkg::*;
#(
    parameter int MAX_UNITS = WEIGHT_MAX_UNITS_D,
    parameter int CNT_W = WEIGHT_CNT_W_D
) (
    input  logic clk,
    input  logic weight_flip_reset,
    input  logic weight_flip,
    output logic weight_limit_exceeded
);
    localparam int unsigned CNT_MAX = (1 << CNT_W) - 1;
    localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_UNITS);
    logic rise;
    logic [CNT_W-1:0] count_q, count_d;
    logic flag_q, flag_d;
    weight_edge_det u_edge (
        .clk(clk),
        .weight_flip_reset(weight_flip_reset),
        .weight_flip(weight_flip),
        .rise_o(rise)
    );
    // count only grows between resets, so the compare alone keeps the flag sticky
    always_comb begin
        count_d = rise ? CNT_W'(sat_inc(32'(count_q), CNT_MAX)) : count_q;
        flag_d = count_d > MAX_C;
    end
    always_ff @(posedge clk) begin
        if (weight_flip_reset) begin
            count_q <= '0;
            flag_q <= 1'b0;
        end else begin
            count_q <= count_d;
            flag_q <= flag_d;
        end
    end
    assign weight_limit_exceeded = flag_q;
endmodule

// File: tb/tb_weight_limit.sv
// tb_weight_limit: randomized self-checking bench against a sampled-history load-count model.
module tb_weight_limit;
`ifdef WEIGHT_SYNC_EN
    localparam int D = 1;
`else
    localparam int D = 0;
`endif
    localparam int MAXU = 8;
    localparam int SAT = 15;
    logic clk = 1'b0;
    logic weight_flip_reset = 1'b1;
    logic weight_flip = 1'b0;
    logic weight_limit_exceeded;
    int checks = 0;
    int errors = 0;
    int m_cnt = 0;
    logic hq[$];

    weight_limit #(.MAX_UNITS(MAXU), .CNT_W(4)) dut (
        .clk(clk),
        .weight_flip_reset(weight_flip_reset),
        .weight_flip(weight_flip),
        .weight_limit_exceeded(weight_limit_exceeded)
    );

    always #2 clk = ~clk;

    // Model: a rise is a 0->1 in the levels sampled at successive posedges; it reaches the
    // count D+1 edges after it is sampled, reset at that edge wins, count saturates at 15.
    task automatic step(input logic wf, input logic r);
        int n;
        logic a, b;
        weight_flip = wf;
        weight_flip_reset = r;
        @(posedge clk);
        n = hq.size();
        a = (n >= 1 + D) ? hq[n-1-D] : 1'b0;
        b = (n >= 2 + D) ? hq[n-2-D] : 1'b0;
        if (r) m_cnt = 0;
        else if (a && !b) m_cnt = (m_cnt >= SAT) ? SAT : m_cnt + 1;
        hq.push_back(wf);
        @(negedge clk);
    endtask

    task automatic pulse(input int hi, input int lo);
        repeat (hi) step(1'b1, 1'b0);
        repeat (lo) step(1'b0, 1'b0);
    endtask

    function automatic logic m_flag();
        return m_cnt > MAXU;
    endfunction

    task automatic test_reset();
        repeat (3) step(1'b0, 1'b1);
        checks++;
        if (weight_limit_exceeded !== 1'b0) begin
            errors++;
            $display("FAIL reset_flag: got %b expected 0", weight_limit_exceeded);
        end
        checks++;
        if (dut.count_q !== 4'd0) begin
            errors++;
            $display("FAIL reset_count: got %0d expected 0", dut.count_q);
        end
    endtask

    task automatic test_fill();
        for (int i = 0; i < 8; i++) begin
            pulse($urandom_range(3, 6), $urandom_range(3, 6));
            checks++;
            if (weight_limit_exceeded !== 1'b0 || weight_limit_exceeded !== m_flag()) begin
                errors++;
                $display("FAIL fill_flag[%0d]: got %b expected 0", i, weight_limit_exceeded);
            end
            checks++;
            if (dut.count_q !== 4'(m_cnt)) begin
                errors++;
                $display("FAIL fill_count[%0d]: got %0d expected %0d", i, dut.count_q, m_cnt);
            end
        end
        checks++;
        if (dut.count_q !== 4'd8) begin
            errors++;
            $display("FAIL fill_total: got %0d expected 8", dut.count_q);
        end
    endtask

    task automatic test_latency();
        int first = 0;
        for (int j = 1; j <= 6; j++) begin
            step(1'b1, 1'b0);
            if (weight_limit_exceeded === 1'b1 && first == 0) first = j;
        end
        checks++;
        if (first != D + 2) begin
            errors++;
            $display("FAIL latency_edges: got %0d expected %0d", first, D + 2);
        end
        repeat (4) step(1'b0, 1'b0);
        checks++;
        if (weight_limit_exceeded !== m_flag() || dut.count_q !== 4'(m_cnt)) begin
            errors++;
            $display("FAIL latency_state: got flag %b count %0d expected flag %b count %0d",
                     weight_limit_exceeded, dut.count_q, m_flag(), m_cnt);
        end
    endtask

    task automatic test_clear();
        step(1'b0, 1'b1);
        checks++;
        if (weight_limit_exceeded !== 1'b0 || dut.count_q !== 4'd0) begin
            errors++;
            $display("FAIL clear_now: got flag %b count %0d expected flag 0 count 0",
                     weight_limit_exceeded, dut.count_q);
        end
        for (int i = 0; i < 8; i++) begin
            pulse($urandom_range(3, 5), $urandom_range(3, 5));
            checks++;
            if (weight_limit_exceeded !== 1'b0 || dut.count_q !== 4'(m_cnt)) begin
                errors++;
                $display("FAIL clear_refill[%0d]: got flag %b count %0d expected flag 0 count %0d",
                         i, weight_limit_exceeded, dut.count_q, m_cnt);
            end
        end
    endtask

    task automatic test_saturate();
        for (int i = 0; i < 20; i++) begin
            pulse($urandom_range(3, 6), $urandom_range(3, 6));
            checks++;
            if (weight_limit_exceeded !== m_flag() || dut.count_q !== 4'(m_cnt)) begin
                errors++;
                $display("FAIL sat_step[%0d]: got flag %b count %0d expected flag %b count %0d",
                         i, weight_limit_exceeded, dut.count_q, m_flag(), m_cnt);
            end
        end
        checks++;
        if (dut.count_q !== 4'd15 || weight_limit_exceeded !== 1'b1) begin
            errors++;
            $display("FAIL sat_final: got flag %b count %0d expected flag 1 count 15",
                     weight_limit_exceeded, dut.count_q);
        end
    endtask

    task automatic test_held_reset();
        repeat (3) step(1'b1, 1'b1);
        repeat (5) step(1'b1, 1'b0);
        checks++;
        if (dut.count_q !== 4'd0 || m_cnt != 0) begin
            errors++;
            $display("FAIL held_release: got count %0d model %0d expected 0", dut.count_q, m_cnt);
        end
        pulse(0, 4);
        pulse(4, 0);
        checks++;
        if (dut.count_q !== 4'd1 || m_cnt != 1) begin
            errors++;
            $display("FAIL held_next_rise: got count %0d model %0d expected 1", dut.count_q, m_cnt);
        end
        pulse(0, 4);
    endtask

    task automatic test_coincident();
        step(1'b0, 1'b1);
        for (int i = 0; i < 8; i++) pulse($urandom_range(3, 5), $urandom_range(3, 5));
        repeat (D + 1) step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        checks++;
        if (dut.count_q !== 4'd0 || weight_limit_exceeded !== 1'b0 || m_cnt != 0) begin
            errors++;
            $display("FAIL coincident: got flag %b count %0d model %0d expected flag 0 count 0",
                     weight_limit_exceeded, dut.count_q, m_cnt);
        end
        repeat (3) step(1'b1, 1'b0);
        pulse(0, 4);
        checks++;
        if (dut.count_q !== 4'd0) begin
            errors++;
            $display("FAIL coincident_after: got count %0d expected 0", dut.count_q);
        end
        weight_flip = 1'b1;
        #1 weight_flip = 1'b0;
        pulse(0, 4);
        checks++;
        if (dut.count_q !== 4'd0 || m_cnt != 0) begin
            errors++;
            $display("FAIL glitch_ignored: got count %0d expected 0", dut.count_q);
        end
        pulse(1, 4);
        checks++;
        if (dut.count_q !== 4'(m_cnt) || weight_limit_exceeded !== m_flag()) begin
            errors++;
            $display("FAIL one_clk_pulse: got count %0d expected %0d", dut.count_q, m_cnt);
        end
    endtask

    task automatic test_random();
        step(1'b0, 1'b1);
        for (int i = 0; i < 300; i++) begin
            step(1'($urandom_range(0, 1)), ($urandom_range(0, 40) == 0));
            checks++;
            if (dut.count_q !== 4'(m_cnt) || weight_limit_exceeded !== m_flag()) begin
                errors++;
                $display("FAIL random[%0d]: got flag %b count %0d expected flag %b count %0d",
                         i, weight_limit_exceeded, dut.count_q, m_flag(), m_cnt);
            end
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_latency();
        test_clear();
        test_saturate();
        test_held_reset();
        test_coincident();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
